// File: rtl/adpll_seq_n_pkg.sv
// Shared encodings and power-up timing defaults for the parametrised ADPLL
// controller sequencer and its bank lock detector.
package adpll_seq_n_pkg;

  typedef enum logic [1:0] {
    MODE_PD   = 2'd0,
    MODE_TEST = 2'd1,
    MODE_RX   = 2'd2,
    MODE_TX   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PU    = 3'd1,
    ST_ACQ   = 3'd2,
    ST_TRACK = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  localparam int PU_TDC_DEF  = 16;
  localparam int PU_INJ_DEF  = 32;
  localparam int PU_DONE_DEF = 48;

  // A programmed lock count of zero behaves as one.
  function automatic logic [3:0] lock_thr(input logic [3:0] cnt);
    return (cnt == 4'd0) ? 4'd1 : cnt;
  endfunction

endpackage

// File: rtl/adpll_lock_det_n.sv
// Two-candidate OTW lock detector: tolerates one-LSB dither between two
// codes and declares lock when either candidate reaches the lock count.
module adpll_lock_det_n
  import adpll_seq_n_pkg::*;
#(
  parameter int WORDW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WORDW-1:0] otw_in,
  input  logic [3:0]              lock_cnt,
  output logic                    lock,
  output logic signed [WORDW-1:0] lock_word
);

  logic signed [WORDW-1:0] aux1_q, aux2_q;
  logic [3:0]              cnt1_q, cnt2_q;
  logic [4:0]              cnt1_inc, cnt2_inc;
  logic [3:0]              thr;
  logic                    hit1, hit2;

  assign thr      = lock_thr(lock_cnt);
  assign hit1     = (otw_in == aux1_q);
  assign hit2     = !hit1 && (otw_in == aux2_q);
  assign cnt1_inc = {1'b0, cnt1_q} + 5'd1;
  assign cnt2_inc = {1'b0, cnt2_q} + 5'd1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lock      = 1'b0;
    lock_word = otw_in;
    if (en && !clr) begin
      if (hit1) begin
        lock      = (cnt1_inc == {1'b0, thr});
        lock_word = aux1_q;
      end else if (hit2) begin
        lock      = (cnt2_inc == {1'b0, thr});
        lock_word = aux2_q;
      end else begin
        lock      = (thr == 4'd1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      aux1_q <= '0;
      aux2_q <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else if (en) begin
      if (clr) begin
        aux1_q <= '0;
        aux2_q <= '0;
        cnt1_q <= '0;
        cnt2_q <= '0;
      end else if (hit1) begin
        cnt1_q <= cnt1_inc[4] ? 4'hF : cnt1_inc[3:0];
      end else if (hit2) begin
        cnt2_q <= cnt2_inc[4] ? 4'hF : cnt2_inc[3:0];
      end else begin
        aux2_q <= aux1_q;
        cnt2_q <= cnt1_q;
        aux1_q <= otw_in;
        cnt1_q <= 4'd1;
      end
    end
  end

endmodule

// File: rtl/adpll_seq_n.sv
// ADPLL controller sequencer: DCO/TDC power-up, coarse-to-fine acquisition
// over NBANK capacitor banks, fine tracking with loss-of-lock relock.
module adpll_seq_n
  import adpll_seq_n_pkg::*;
#(
  parameter int NBANK   = 3,
  parameter int WORDW   = 8,
  parameter int TW      = 10,
  parameter int PU_TDC  = PU_TDC_DEF,
  parameter int PU_INJ  = PU_INJ_DEF,
  parameter int PU_DONE = PU_DONE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic [25:0]                 fcw,
  input  logic signed [WORDW-1:0]     otw_in,
  input  logic [3:0]                  lock_cnt,
  input  logic [TW-1:0]               acq_timeout,
  input  logic [TW-1:0]               lock_time,
  input  logic [3:0]                  lol_cnt,
  input  logic                        beta_nz,
  input  logic [NBANK*WORDW-1:0]      bank_word_test,
  input  logic                        dco_pd_test,
  input  logic                        tdc_pd_test,
  input  logic                        tdc_pd_inj_test,
  output logic                        dco_pd,
  output logic                        tdc_pd,
  output logic                        tdc_pd_inj,
  output logic                        rst_accum,
  output logic [$clog2(NBANK)-1:0]    bank_sel,
  output logic [NBANK*WORDW-1:0]      bank_word,
  output logic                        en_integral,
  output logic                        en_mod,
  output logic                        channel_lock,
  output logic                        acq_fail,
  output logic [3:0]                  relock_count,
  output logic [2:0]                  state
);

  localparam int                SELW      = $clog2(NBANK);
  localparam logic [SELW-1:0]   LAST_BANK = SELW'(NBANK - 1);
  localparam logic [WORDW-1:0]  OTW_MAX   = {1'b0, {(WORDW-1){1'b1}}};
  localparam logic [WORDW-1:0]  OTW_MIN   = {1'b1, {(WORDW-1){1'b0}}};

  mode_e mode_i;
  assign mode_i = mode_e'(mode);

  state_e                        state_q, state_d;
  logic [TW-1:0]                 cnt_q, cnt_d, cnt_nxt;
  logic [SELW-1:0]               bank_sel_q, bank_sel_d;
  logic [NBANK-1:0][WORDW-1:0]   frozen_q, frozen_d;
  logic                          dco_pd_q, dco_pd_d;
  logic                          tdc_pd_q, tdc_pd_d;
  logic                          tdc_pd_inj_q, tdc_pd_inj_d;
  logic                          rst_accum_q, rst_accum_d;
  logic                          en_integral_q, en_integral_d;
  logic                          en_mod_q, en_mod_d;
  logic                          channel_lock_q, channel_lock_d;
  logic                          acq_fail_q, acq_fail_d;
  logic [3:0]                    relock_q, relock_d;
  logic [3:0]                    lol_run_q, lol_run_d;
  logic [25:0]                   fcw_last_q;
  logic [1:0]                    mode_last_q;

  logic                          restart;
  logic                          full_scale;
  logic                          live;
  logic                          det_lock;
  logic signed [WORDW-1:0]       det_word;

  assign restart    = (fcw != fcw_last_q) || (mode != mode_last_q);
  assign full_scale = (otw_in == OTW_MAX) || (otw_in == OTW_MIN);
  assign cnt_nxt    = (&cnt_q) ? cnt_q : cnt_q + TW'(1);

  // The cycle carrying rst_accum is the detector clear cycle of a new bank.
  adpll_lock_det_n #(.WORDW(WORDW)) u_lock_det (
    .clk       (clk),
    .rst       (rst),
    .clr       (rst_accum_q),
    .en        (en && (state_q == ST_ACQ)),
    .otw_in    (otw_in),
    .lock_cnt  (lock_cnt),
    .lock      (det_lock),
    .lock_word (det_word)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bank_sel_d     = bank_sel_q;
    frozen_d       = frozen_q;
    dco_pd_d       = dco_pd_q;
    tdc_pd_d       = tdc_pd_q;
    tdc_pd_inj_d   = tdc_pd_inj_q;
    rst_accum_d    = 1'b0;
    en_integral_d  = en_integral_q;
    en_mod_d       = en_mod_q;
    channel_lock_d = channel_lock_q;
    acq_fail_d     = acq_fail_q;
    relock_d       = relock_q;
    lol_run_d      = '0;

    if (restart) begin
      state_d        = ST_IDLE;
      cnt_d          = '0;
      bank_sel_d     = '0;
      frozen_d       = '0;
      en_integral_d  = 1'b0;
      en_mod_d       = 1'b0;
      channel_lock_d = 1'b0;
      acq_fail_d     = 1'b0;
      relock_d       = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mode_i == MODE_PD) begin
            dco_pd_d     = 1'b1;
            tdc_pd_d     = 1'b1;
            tdc_pd_inj_d = 1'b1;
          end else if (mode_i == MODE_RX || mode_i == MODE_TX) begin
            state_d  = ST_PU;
            cnt_d    = '0;
            dco_pd_d = 1'b0;
          end
        end

        ST_PU: begin
          dco_pd_d = 1'b0;
          cnt_d    = cnt_nxt;
          if (cnt_nxt == TW'(PU_TDC)) tdc_pd_d     = 1'b0;
          if (cnt_nxt == TW'(PU_INJ)) tdc_pd_inj_d = 1'b0;
          if (cnt_nxt == TW'(PU_DONE)) begin
            state_d     = ST_ACQ;
            bank_sel_d  = '0;
            rst_accum_d = 1'b1;
            cnt_d       = '0;
          end
        end

        ST_ACQ: begin
          cnt_d = cnt_nxt;
          // Lock is tested first so it wins over a coincident timeout.
          if (det_lock) begin
            cnt_d = '0;
            if (bank_sel_q == LAST_BANK) begin
              state_d       = ST_TRACK;
              en_integral_d = (mode_i == MODE_RX) && beta_nz;
            end else begin
              frozen_d[bank_sel_q] = det_word;
              bank_sel_d           = bank_sel_q + SELW'(1);
              rst_accum_d          = 1'b1;
            end
          end else if (acq_timeout != '0 && cnt_nxt == acq_timeout) begin
            state_d    = ST_FAIL;
            acq_fail_d = 1'b1;
          end
        end

        ST_TRACK: begin
          cnt_d         = cnt_nxt;
          en_integral_d = (mode_i == MODE_RX) && beta_nz;
          en_mod_d      = channel_lock_q && (mode_i == MODE_TX);
          if (cnt_nxt == lock_time) channel_lock_d = 1'b1;
          if (channel_lock_q && full_scale) begin
            lol_run_d = (&lol_run_q) ? lol_run_q : lol_run_q + 4'd1;
            if (lol_cnt != 4'd0 && lol_run_d == lol_cnt) begin
              state_d        = ST_ACQ;
              bank_sel_d     = '0;
              rst_accum_d    = 1'b1;
              cnt_d          = '0;
              lol_run_d      = '0;
              channel_lock_d = 1'b0;
              en_mod_d       = 1'b0;
              en_integral_d  = 1'b0;
              relock_d       = (&relock_q) ? relock_q : relock_q + 4'd1;
            end
          end
        end

        ST_FAIL: ;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: the frozen words are a handful of flops, so they reset with the rest.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bank_sel_q     <= '0;
      frozen_q       <= '0;
      dco_pd_q       <= 1'b1;
      tdc_pd_q       <= 1'b1;
      tdc_pd_inj_q   <= 1'b1;
      rst_accum_q    <= 1'b0;
      en_integral_q  <= 1'b0;
      en_mod_q       <= 1'b0;
      channel_lock_q <= 1'b0;
      acq_fail_q     <= 1'b0;
      relock_q       <= '0;
      lol_run_q      <= '0;
      fcw_last_q     <= fcw;
      mode_last_q    <= mode;
    end else if (en) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bank_sel_q     <= bank_sel_d;
      frozen_q       <= frozen_d;
      dco_pd_q       <= dco_pd_d;
      tdc_pd_q       <= tdc_pd_d;
      tdc_pd_inj_q   <= tdc_pd_inj_d;
      rst_accum_q    <= rst_accum_d;
      en_integral_q  <= en_integral_d;
      en_mod_q       <= en_mod_d;
      channel_lock_q <= channel_lock_d;
      acq_fail_q     <= acq_fail_d;
      relock_q       <= relock_d;
      lol_run_q      <= lol_run_d;
      fcw_last_q     <= fcw;
      mode_last_q    <= mode;
    end
  end

  assign live = ((state_q == ST_ACQ) || (state_q == ST_TRACK)) && !rst_accum_q;

  always_comb begin
    bank_word = frozen_q;
    for (int k = 0; k < NBANK; k++) begin
      if (mode_i == MODE_TEST)
        bank_word[k*WORDW +: WORDW] = bank_word_test[k*WORDW +: WORDW];
      else if (live && bank_sel_q == SELW'(k))
        bank_word[k*WORDW +: WORDW] = otw_in;
    end
  end

  assign dco_pd       = (mode_i == MODE_TEST) ? dco_pd_test     : dco_pd_q;
  assign tdc_pd       = (mode_i == MODE_TEST) ? tdc_pd_test     : tdc_pd_q;
  assign tdc_pd_inj   = (mode_i == MODE_TEST) ? tdc_pd_inj_test : tdc_pd_inj_q;
  assign rst_accum    = rst_accum_q;
  assign bank_sel     = bank_sel_q;
  assign en_integral  = en_integral_q;
  assign en_mod       = en_mod_q;
  assign channel_lock = channel_lock_q;
  assign acq_fail     = acq_fail_q;
  assign relock_count = relock_q;
  assign state        = state_q;

endmodule

// File: tb/tb_adpll_seq_n.sv
// Directed bench for adpll_seq_n: power-up timing, bank acquisition with a
// frozen-word scoreboard, tracking, loss of lock, timeout and TEST muxing.
module tb_adpll_seq_n;

  logic        clk = 1'b0;
  logic        rst, en, beta_nz;
  logic [1:0]  mode;
  logic [25:0] fcw;
  logic [7:0]  otw;
  logic [3:0]  lock_cnt, lol_cnt;
  logic [9:0]  acq_timeout, lock_time;
  logic [23:0] bwt;
  logic        dco_pd_test, tdc_pd_test, tdc_pd_inj_test;
  logic        dco_pd, tdc_pd, tdc_pd_inj, rst_accum;
  logic [1:0]  bank_sel;
  logic [23:0] bank_word;
  logic        en_integral, en_mod, channel_lock, acq_fail;
  logic [3:0]  relock_count;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    int         bank;
    logic [7:0] word;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  adpll_seq_n dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fcw(fcw), .otw_in(otw),
    .lock_cnt(lock_cnt), .acq_timeout(acq_timeout), .lock_time(lock_time),
    .lol_cnt(lol_cnt), .beta_nz(beta_nz), .bank_word_test(bwt),
    .dco_pd_test(dco_pd_test), .tdc_pd_test(tdc_pd_test),
    .tdc_pd_inj_test(tdc_pd_inj_test), .dco_pd(dco_pd), .tdc_pd(tdc_pd),
    .tdc_pd_inj(tdc_pd_inj), .rst_accum(rst_accum), .bank_sel(bank_sel),
    .bank_word(bank_word), .en_integral(en_integral), .en_mod(en_mod),
    .channel_lock(channel_lock), .acq_fail(acq_fail),
    .relock_count(relock_count), .state(state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] word_of(input int k);
    return bank_word[k*8 +: 8];
  endfunction

  task automatic sb_push(input string tag, input int bank, input logic [7:0] w);
    exp_t e;
    e.tag  = tag;
    e.bank = bank;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    e = sb.pop_front();
    check(e.tag, word_of(e.bank), e.word);
  endtask

  // lock_cnt = 8: dither x/x+1 six times, then x until its count reaches 8.
  task automatic acquire8(input int k, input logic [7:0] x);
    check($sformatf("b%0d_rst_accum_on", k), rst_accum, 1);
    otw = 8'd99;
    #1;
    check($sformatf("b%0d_masked_in_reset", k), word_of(k), (k == 2) ? 8'd0 : 8'd0);
    tick(1);
    check($sformatf("b%0d_rst_accum_off", k), rst_accum, 0);
    for (int i = 0; i < 11; i++) begin
      otw = (i < 6 && (i % 2) == 1) ? x + 8'd1 : x;
      #1;
      if (i == 1) check($sformatf("b%0d_live", k), word_of(k), x + 8'd1);
      if (i == 10) begin
        check($sformatf("b%0d_no_early_lock", k), bank_sel, k);
        if (k < 2) sb_push($sformatf("b%0d_frozen", k), k, x);
      end
      tick(1);
    end
    if (k < 2) begin
      check($sformatf("b%0d_advance", k), bank_sel, k + 1);
      sb_pop();
    end else begin
      check("track_entry", state, 3);
      check("track_bank_sel", bank_sel, 2);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'd0; fcw = 26'h0123456; otw = 8'd0;
    lock_cnt = 4'd8; acq_timeout = 10'd0; lock_time = 10'd480; lol_cnt = 4'd4;
    beta_nz = 1'b1; bwt = 24'hA53C7E;
    dco_pd_test = 1'b0; tdc_pd_test = 1'b1; tdc_pd_inj_test = 1'b0;

    #12;
    check("rst_state", state, 0);
    check("rst_pd", {dco_pd, tdc_pd, tdc_pd_inj}, 3'b111);
    check("rst_flags", {rst_accum, en_integral, en_mod, channel_lock, acq_fail}, 5'b0);
    check("rst_relock", relock_count, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_words", bank_word, 0);
    #11 rst = 1'b0;
    tick(1);
    check("idle_pd_mode", state, 0);

    // Power-up sequencing in RX; mode change restarts through IDLE.
    mode = 2'd2;
    tick(1);
    check("restart_idle", state, 0);
    tick(1);
    check("pu_entry", state, 1);
    check("pu_dco_pd", dco_pd, 0);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    check("en_low_hold", state, 1);
    tick(15);
    check("tdc_pd_at15", tdc_pd, 1);
    tick(1);
    check("tdc_pd_at16", tdc_pd, 0);
    check("inj_at16", tdc_pd_inj, 1);
    tick(15);
    check("inj_at31", tdc_pd_inj, 1);
    tick(1);
    check("inj_at32", tdc_pd_inj, 0);
    tick(15);
    check("pu_at47", state, 1);
    tick(1);
    check("acq_at48", state, 2);
    check("acq_bank0", bank_sel, 0);

    acquire8(0, 8'd5);
    acquire8(1, 8'hFD);
    acquire8(2, 8'd17);

    // RX tracking.
    check("rx_en_integral", en_integral, 1);
    otw = 8'd10;
    #1;
    check("fine_bank_live", word_of(2), 8'd10);
    check("bank0_held", word_of(0), 8'd5);
    check("bank1_held", word_of(1), 8'hFD);
    tick(479);
    check("lock_at479", channel_lock, 0);
    tick(1);
    check("lock_at480", channel_lock, 1);
    check("rx_no_mod", en_mod, 0);

    // Three saturated cycles are not enough; four (mixed +/- full scale) are.
    otw = 8'd127;
    tick(3);
    otw = 8'd10;
    tick(1);
    check("lol3_lock", channel_lock, 1);
    check("lol3_relock", relock_count, 0);
    otw = 8'd127;
    tick(2);
    otw = 8'h80;
    tick(1);
    check("lol_pre_event", channel_lock, 1);
    tick(1);
    check("lol_state", state, 2);
    check("lol_bank_sel", bank_sel, 0);
    check("lol_lock_clr", {channel_lock, en_integral}, 2'b00);
    check("lol_relock", relock_count, 1);
    check("lol_rst_accum", rst_accum, 1);
    check("lol_words_kept", word_of(1), 8'hFD);

    // Channel change mid-ACQ, then a TX run with lock_cnt = 1.
    fcw = fcw + 26'd1;
    mode = 2'd3;
    tick(1);
    check("fcw_restart", state, 0);
    check("fcw_words_clr", bank_word, 0);
    check("fcw_relock_clr", relock_count, 0);
    tick(1);
    check("tx_pu", state, 1);
    lock_cnt = 4'd1;
    lock_time = 10'd5;
    tick(48);
    check("tx_acq", state, 2);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      otw = 8'd40 + 8'(k);
      if (k < 2) sb_push($sformatf("tx_b%0d_frozen", k), k, otw);
      tick(1);
      if (k < 2) sb_pop();
    end
    check("tx_track", state, 3);
    check("tx_no_integral", en_integral, 0);
    tick(4);
    check("tx_lock_at4", channel_lock, 0);
    tick(1);
    check("tx_lock_at5", channel_lock, 1);
    check("tx_mod_same", en_mod, 0);
    tick(1);
    check("tx_mod_next", en_mod, 1);

    // Timeout: coincident lock wins in bank 0, then bank 1 times out.
    fcw = fcw + 26'd1;
    mode = 2'd2;
    acq_timeout = 10'd2;
    lock_cnt = 4'd0;
    tick(1);
    check("fail_run_restart", en_mod, 0);
    tick(49);
    check("fail_run_acq", state, 2);
    tick(1);
    otw = 8'hF9;
    sb_push("lock_beats_timeout_word", 0, 8'hF9);
    tick(1);
    check("lock_beats_timeout", {state, bank_sel}, {3'd2, 2'd1});
    sb_pop();
    acq_timeout = 10'd20;
    lock_cnt = 4'd8;
    for (int i = 0; i < 20; i++) begin
      otw = 8'(i * 3 + 1);
      tick(1);
      if (i == 18) check("timeout_at19", state, 2);
    end
    check("timeout_at20", state, 4);
    check("acq_fail_set", acq_fail, 1);
    check("fail_word0_held", word_of(0), 8'hF9);
    check("fail_word1_frozen", word_of(1), 8'd0);
    tick(5);
    check("fail_sticky", {state, acq_fail}, {3'd4, 1'b1});
    fcw = fcw + 26'd1;
    tick(1);
    check("fail_exit", state, 0);
    check("fail_clr", acq_fail, 0);
    check("fail_words_clr", bank_word, 0);

    // TEST mode muxing.
    mode = 2'd1;
    #1;
    check("test_words", bank_word, bwt);
    check("test_pd", {dco_pd, tdc_pd, tdc_pd_inj}, {dco_pd_test, tdc_pd_test, tdc_pd_inj_test});
    tick(2);
    check("test_idle", state, 0);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adpll_seq_n.md
Name: adpll_seq_n

Overview:
- Parametrised successor to the single-channel ADPLL controller sequencer.
- Sequences DCO/TDC power-up, then performs coarse-to-fine acquisition over NBANK capacitor banks, then runs fine tracking.
- Lock-detect count, acquisition timeout and lock time are programmable at run time. Adds per-bank timeout/failure and loss-of-lock relock, which the previous controller lacked.
- Sits between the loop filter (supplies saturated, rounded OTW) and the row/col bank decoders.

Parameters:
- NBANK, 3, number of capacitor banks, acquired coarse (index 0) to fine (NBANK-1); min 2.
- WORDW, 8, signed bank word width (all banks).
- TW, 10, width of time counters and programmable times.
- PU_TDC, 16, cycles after PU entry until tdc_pd released.
- PU_INJ, 32, cycles until tdc_pd_inj released.
- PU_DONE, 48, cycles until acquisition starts.

Ports:
- clk  in  1  controller clock; all registers update on falling edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  clock enable; when low, all state holds.
- mode  in  2  PD=0, TEST=1, RX=2, TX=3.
- fcw  in  26  channel word; any change restarts.
- otw_in  in  WORDW  signed saturated rounded OTW from loop filter.
- lock_cnt  in  4  consecutive equal-OTW count required for bank lock; 0 treated as 1.
- acq_timeout  in  TW  max cycles per bank; 0 = no timeout.
- lock_time  in  TW  tracking cycles before channel_lock.
- lol_cnt  in  4  consecutive saturated-OTW cycles in TRACK that declare loss of lock; 0 = disabled.
- beta_nz  in  1  integral path requested (RX).
- bank_word_test  in  NBANK*WORDW  TEST-mode words.
- dco_pd_test, tdc_pd_test, tdc_pd_inj_test  in  1  TEST-mode power-downs.
- dco_pd, tdc_pd, tdc_pd_inj  out  1  analog power-downs.
- rst_accum  out  1  loop accumulator/filter reset pulse.
- bank_sel  out  $clog2(NBANK)  bank currently driven by the loop.
- bank_word  out  NBANK*WORDW  flattened signed words; bank k at [k*WORDW +: WORDW].
- en_integral  out  1  enable integral path.
- en_mod  out  1  enable TX modulation.
- channel_lock  out  1  channel locked.
- acq_fail  out  1  sticky acquisition timeout.
- relock_count  out  4  saturating count of loss-of-lock events.
- state  out  3  IDLE=0, PU=1, ACQ=2, TRACK=3, FAIL=4.

Behaviour:
- Reset values:
  - state IDLE; all frozen words 0.
  - dco_pd, tdc_pd, tdc_pd_inj = 1.
  - rst_accum, en_integral, en_mod, channel_lock, acq_fail = 0.
  - relock_count 0; bank_sel 0.
  - fcw_last and mode_last load the current inputs.
- Restart: fcw != fcw_last or mode != mode_last on an enabled edge → IDLE next edge. This has priority over every other transition. It clears channel_lock, en_mod, en_integral, acq_fail, relock_count and the frozen words.
- IDLE:
  - mode PD → all pd = 1.
  - mode RX/TX → PU with counter = 0.
  - mode TEST → stay in IDLE.
- PU:
  - dco_pd = 0; counter increments.
  - counter == PU_TDC → tdc_pd = 0; counter == PU_INJ → tdc_pd_inj = 0.
  - counter == PU_DONE → ACQ, bank_sel = 0, rst_accum = 1 for exactly one cycle, counter = 0.
- ACQ (bank k = bank_sel):
  - Two-candidate lock detector, cleared on each bank entry: candidates aux1/aux2 with counts.
  - otw_in == aux1 → cnt1++; else otw_in == aux2 → cnt2++; else aux2 ← aux1 (with its count), aux1 ← otw_in, cnt1 = 1.
  - Lock when the incremented count == max(lock_cnt, 1). Frozen word k ← matching candidate.
  - On lock, k < NBANK-1 → bank_sel++, one-cycle rst_accum, counter = 0.
  - On lock, k == NBANK-1 → TRACK, counter = 0. The finest bank does not freeze; it stays live.
  - counter reaching acq_timeout (≠0) without lock → FAIL, acq_fail = 1.
- TRACK:
  - counter increments, saturating at all-ones.
  - RX: en_integral = beta_nz.
  - counter == lock_time → channel_lock = 1.
  - TX: en_mod = 1 from the cycle after channel_lock is 1.
  - Loss of lock: lol_cnt ≠ 0 and otw_in at ±full-scale (max or min signed) for lol_cnt consecutive cycles while channel_lock = 1. Response: channel_lock, en_mod, en_integral = 0; relock_count++ (saturating at 15); ACQ bank 0; rst_accum pulse.
- FAIL: hold all words and power state; exit only via restart or rst.
- bank_word per bank:
  - TEST mode → bank_word_test.
  - Bank == bank_sel in ACQ/TRACK with rst_accum = 0 → otw_in.
  - Otherwise → frozen value (0 for unreached banks).
- Power-down muxing: TEST → *_test inputs; otherwise registered state.
- Simultaneous lock and timeout on the same edge → lock wins.
- rst mid-operation returns to reset values asynchronously.

Decomposition:
- Shared package: mode encodings, state encodings, PU timing defaults.
- One sub-module: adpll_lock_det_n (WORDW parameter).
  - Holds the two-candidate detector.
  - Ports: clk, rst, clr, en, otw_in, lock_cnt, lock, lock_word.

Test Plan:
- Reset, then mode=RX → dco_pd falls at PU entry; tdc_pd at counter 16; tdc_pd_inj at 32. ACQ entered at 48 with a single rst_accum pulse.
- ACQ, NBANK=3, lock_cnt=8, otw_in alternating 5/6 then constant 5 → bank 0 freezes to 5 on the 8th equal sample. bank_sel=1 with rst_accum pulse; repeat for banks 1 and 2 → TRACK.
- TRACK RX, lock_time=480, beta_nz=1 → en_integral=1 on entry; channel_lock=1 at counter 480. TX variant: en_mod=1 one cycle later.
- acq_timeout=20, otw_in changing every cycle → FAIL at 20 cycles; acq_fail=1; words held. A subsequent fcw change → IDLE and acq_fail=0.
- TRACK locked, lol_cnt=4, otw_in=127 for 4 cycles → channel_lock=0, relock_count=1, ACQ bank 0. Only 3 cycles at 127 → no event.
- fcw change mid-ACQ → IDLE on next edge with frozen words 0. mode=TEST → bank_word and pd outputs equal the test inputs.
